// File: rtl/sprite_anim_ctrl_if.sv
// rtl/sprite_anim_ctrl_if.sv - request/animation signal bundle for sprite_anim_ctrl
//
// Purpose: groups the frame tick, action requests and animation outputs.
// Signals:
//   frame_tick   - one-cycle pulse per video frame
//   action_req   - level requests, bit i = action i, bit 0 highest priority
//   sprite_index - 0 = idle sprite, i+1 = action i
//   frame_index  - current animation frame, 0 in idle
//   busy         - an action animation is playing
//   action_done  - one-cycle pulse when an action finishes its last frame
// Modports: master drives tick/requests, slave is the animation controller.
interface sprite_anim_ctrl_if #(
    parameter int NUM_ACTIONS       = 2,
    parameter int FRAMES_PER_ACTION = 4
);
    localparam int IDX_W = $clog2(NUM_ACTIONS + 1);
    localparam int FRM_W = (FRAMES_PER_ACTION > 2) ? $clog2(FRAMES_PER_ACTION) : 1;

    logic                   frame_tick;
    logic [NUM_ACTIONS-1:0] action_req;
    logic [IDX_W-1:0]       sprite_index;
    logic [FRM_W-1:0]       frame_index;
    logic                   busy;
    logic                   action_done;

    modport master (
        output frame_tick,
        output action_req,
        input  sprite_index,
        input  frame_index,
        input  busy,
        input  action_done
    );

    modport slave (
        input  frame_tick,
        input  action_req,
        output sprite_index,
        output frame_index,
        output busy,
        output action_done
    );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - timed sprite animation sequencer with priority and pre-emption
//
// Purpose: latches the highest-priority action request, steps its frames on
// the video frame tick, restarts on a higher-priority request, chains into a
// pending request on completion, and otherwise returns to idle.
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset
//   bus     - sprite_anim_ctrl_if.slave (frame_tick, action_req in;
//             sprite_index, frame_index, busy, action_done out)
module sprite_anim_ctrl #(
    parameter int NUM_ACTIONS       = 2,
    parameter int FRAMES_PER_ACTION = 4,
    parameter int FRAME_TICKS       = 6
) (
    input  logic Clk,
    input  logic Reset_n,
    sprite_anim_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ACTIONS + 1);
    localparam int FRM_W = (FRAMES_PER_ACTION > 2) ? $clog2(FRAMES_PER_ACTION) : 1;
    localparam int TCK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(FRAMES_PER_ACTION - 1);
    localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(FRAME_TICKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] sprite_q, sprite_n;
    logic [FRM_W-1:0] frame_q, frame_n;
    logic [TCK_W-1:0] tick_q, tick_n;
    logic             done_q, done_n;

    logic             has_req;
    logic [IDX_W-1:0] win_sprite;
    logic             frame_end;
    logic             last_end;
    logic             preempt;

    // Winner is the lowest set request bit, expressed directly as its sprite
    // code (index + 1) so it compares against the running sprite_index.
    always_comb begin
        win_sprite = '0;
        for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
            if (bus.action_req[i]) begin
                win_sprite = IDX_W'(i + 1);
            end
        end
    end

    assign has_req   = |bus.action_req;
    assign frame_end = bus.frame_tick && (tick_q == TICK_LAST);
    assign last_end  = frame_end && (frame_q == FRM_LAST);
    // A smaller sprite code means a higher-priority action.
    assign preempt   = has_req && (win_sprite < sprite_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            sprite_q <= '0;
            frame_q  <= '0;
            tick_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            sprite_q <= sprite_n;
            frame_q  <= frame_n;
            tick_q   <= tick_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        sprite_n = sprite_q;
        frame_n  = frame_q;
        tick_n   = tick_q;
        done_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ticks are ignored here; only a request starts an animation.
                if (has_req) begin
                    state_n  = PLAY;
                    sprite_n = win_sprite;
                    frame_n  = '0;
                    tick_n   = '0;
                end
            end

            PLAY: begin
                if (last_end) begin
                    // Completion outranks pre-emption in the same cycle.
                    done_n  = 1'b1;
                    frame_n = '0;
                    tick_n  = '0;
                    if (has_req) begin
                        sprite_n = win_sprite;
                    end else begin
                        state_n  = IDLE;
                        sprite_n = '0;
                    end
                end else if (preempt) begin
                    sprite_n = win_sprite;
                    frame_n  = '0;
                    tick_n   = '0;
                end else if (frame_end) begin
                    tick_n  = '0;
                    frame_n = frame_q + 1'b1;
                end else if (bus.frame_tick) begin
                    tick_n = tick_q + 1'b1;
                end
            end

            default: begin
                state_n  = IDLE;
                sprite_n = '0;
                frame_n  = '0;
                tick_n   = '0;
            end
        endcase
    end

    assign bus.sprite_index = sprite_q;
    assign bus.frame_index  = frame_q;
    assign bus.busy         = (state_q == PLAY);
    assign bus.action_done  = done_q;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb/tb_sprite_anim_ctrl.sv - self-checking bench for sprite_anim_ctrl
module tb_sprite_anim_ctrl;
    localparam int NA  = 2;
    localparam int FPA = 4;
    localparam int FT  = 2;
    localparam int DUR = FPA * FT;

    logic Clk;
    logic Reset_n;

    sprite_anim_ctrl_if #(.NUM_ACTIONS(NA), .FRAMES_PER_ACTION(FPA)) bus ();

    sprite_anim_ctrl #(
        .NUM_ACTIONS(NA),
        .FRAMES_PER_ACTION(FPA),
        .FRAME_TICKS(FT)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: current action (0 = idle, else index+1) and the number of
    // frame ticks counted since that action was entered.
    int m_act;
    int m_elapsed;
    int m_done;

    function automatic int lowest(input logic [NA-1:0] r);
        for (int i = 0; i < NA; i++) if (r[i]) return i;
        return -1;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_act = 0; m_elapsed = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_act == 0) begin
                if (bus.action_req != 0) begin
                    m_act = lowest(bus.action_req) + 1;
                    m_elapsed = 0;
                end
            end else if (bus.frame_tick && m_elapsed == DUR - 1) begin
                m_done = 1;
                m_elapsed = 0;
                m_act = (bus.action_req != 0) ? lowest(bus.action_req) + 1 : 0;
            end else if (bus.action_req != 0 && lowest(bus.action_req) + 1 < m_act) begin
                m_act = lowest(bus.action_req) + 1;
                m_elapsed = 0;
            end else if (bus.frame_tick) begin
                m_elapsed++;
            end
        end
    end

    int  done_cnt = 0;
    bit  watch_busy = 0;
    bit  busy_dropped = 0;

    always @(negedge Clk) begin
        chk("sprite_index", int'(bus.sprite_index), m_act);
        chk("frame_index", int'(bus.frame_index), (m_act != 0) ? m_elapsed / FT : 0);
        chk("busy", int'(bus.busy), (m_act != 0) ? 1 : 0);
        chk("action_done", int'(bus.action_done), m_done);
        if (bus.action_done) done_cnt++;
        if (watch_busy && !bus.busy) busy_dropped = 1;
    end

    task automatic cyc(input logic [NA-1:0] req, input logic tick);
        bus.action_req = req;
        bus.frame_tick = tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input logic [NA-1:0] req, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(req, 1'b1);
            cyc(req, 1'b0);
        end
    endtask

    int d0;

    initial begin
        // 1. Reset held with requests and ticks active
        Reset_n = 1'b0;
        bus.action_req = 2'b11;
        bus.frame_tick = 1'b0;
        for (int i = 0; i < 4; i++) cyc(2'b11, i[0]);
        chk("rst_sprite", int'(bus.sprite_index), 0);
        chk("rst_frame", int'(bus.frame_index), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.action_done), 0);
        bus.action_req = 2'b00;
        Reset_n = 1'b1;
        cyc(2'b00, 1'b1);
        cyc(2'b00, 1'b0);
        chk("idle_sprite", int'(bus.sprite_index), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // 2. Single jump
        d0 = done_cnt;
        cyc(2'b10, 1'b0);
        chk("jump_start_sprite", int'(bus.sprite_index), 2);
        chk("jump_start_frame", int'(bus.frame_index), 0);
        chk("jump_start_busy", int'(bus.busy), 1);
        ticks(2'b00, 2);
        chk("jump_frame1", int'(bus.frame_index), 1);
        ticks(2'b00, 4);
        chk("jump_frame3", int'(bus.frame_index), 3);
        ticks(2'b00, 1);
        cyc(2'b00, 1'b1);
        chk("jump_done_pulse", int'(bus.action_done), 1);
        chk("jump_end_sprite", int'(bus.sprite_index), 0);
        chk("jump_end_busy", int'(bus.busy), 0);
        cyc(2'b00, 1'b0);
        chk("jump_done_clear", int'(bus.action_done), 0);
        chk("jump_done_count", done_cnt - d0, 1);

        // 3. Simultaneous request, jump held through punch, chains at completion
        cyc(2'b11, 1'b0);
        chk("both_sprite", int'(bus.sprite_index), 1);
        ticks(2'b10, 7);
        chk("punch_held_sprite", int'(bus.sprite_index), 1);
        cyc(2'b10, 1'b1);
        chk("chain_sprite", int'(bus.sprite_index), 2);
        chk("chain_frame", int'(bus.frame_index), 0);
        chk("chain_done", int'(bus.action_done), 1);
        cyc(2'b00, 1'b0);
        ticks(2'b00, DUR);
        cyc(2'b00, 1'b0);
        chk("t3_idle", int'(bus.sprite_index), 0);

        // 4. Pre-emption at frame 2
        d0 = done_cnt;
        cyc(2'b10, 1'b0);
        ticks(2'b00, 4);
        chk("pre_frame2", int'(bus.frame_index), 2);
        cyc(2'b01, 1'b0);
        chk("pre_sprite", int'(bus.sprite_index), 1);
        chk("pre_frame", int'(bus.frame_index), 0);
        chk("pre_no_done", done_cnt - d0, 0);
        ticks(2'b00, DUR);
        cyc(2'b00, 1'b0);
        chk("pre_done_count", done_cnt - d0, 1);
        chk("pre_idle", int'(bus.busy), 0);

        // 5. Chaining with jump held continuously
        d0 = done_cnt;
        cyc(2'b10, 1'b0);
        watch_busy = 1;
        ticks(2'b10, 3 * DUR);
        chk("chain_count", done_cnt - d0, 3);
        chk("chain_sprite_held", int'(bus.sprite_index), 2);
        watch_busy = 0;
        chk("chain_busy_never_low", int'(busy_dropped), 0);
        ticks(2'b00, DUR);
        cyc(2'b00, 1'b0);
        chk("chain_final_count", done_cnt - d0, 4);

        // 6. Async reset mid-play at frame 3
        d0 = done_cnt;
        cyc(2'b10, 1'b0);
        ticks(2'b00, 6);
        chk("ar_frame3", int'(bus.frame_index), 3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar_sprite", int'(bus.sprite_index), 0);
        chk("ar_frame", int'(bus.frame_index), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_done", int'(bus.action_done), 0);
        cyc(2'b00, 1'b1);
        Reset_n = 1'b1;
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        chk("ar_no_done", done_cnt - d0, 0);
        chk("ar_idle", int'(bus.sprite_index), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
